// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module      : wb_rr_arbiter
// Description : Round-robin Wishbone arbiter sharing one slave port between
//               NUM_MASTERS requesters. The grant is held for the whole bus
//               cycle (while the owner keeps cyc high). A bus watchdog aborts
//               a strobe that the slave never acks.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               m_*_i / m_*_o       - packed master-side Wishbone signals
//               s_*_o / s_*_i       - slave-side Wishbone signals
//               grant_o             - one-hot current owner, 0 when idle
//               timeout_o           - sticky watchdog-abort flag
//               timeout_clr_i       - clears timeout_o
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [32*NUM_MASTERS-1:0]   m_adr_i,
    input  logic [32*NUM_MASTERS-1:0]   m_dat_i,
    input  logic [4*NUM_MASTERS-1:0]    m_sel_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    output logic [31:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic [31:0]                 s_adr_o,
    output logic [31:0]                 s_dat_o,
    output logic [3:0]                  s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    input  logic [31:0]                 s_dat_i,
    input  logic                        s_ack_i,
    output logic [NUM_MASTERS-1:0]      grant_o,
    output logic                        timeout_o,
    input  logic                        timeout_clr_i
);

    localparam int c_idx_w  = $clog2(NUM_MASTERS);
    localparam int c_wdog_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_grant = 1'b1;
    localparam logic [NUM_MASTERS-1:0] c_one = NUM_MASTERS'(1);

    logic [0:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [c_idx_w-1:0]     r_gidx;
    logic [c_idx_w-1:0]     r_last;
    logic [c_wdog_w-1:0]    r_wdog;
    logic                   r_abort;
    logic [NUM_MASTERS-1:0] r_err;
    logic                   r_timeout;

    logic [0:0]             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [c_idx_w-1:0]     w_gidx_nxt;
    logic [c_idx_w-1:0]     w_last_nxt;
    logic                   w_found;
    logic [c_idx_w-1:0]     w_pick;
    logic [c_idx_w-1:0]     w_cand;
    logic [31:0]            w_adr;
    logic [31:0]            w_dat;
    logic [3:0]             w_sel;
    logic                   w_we;
    logic                   w_cyc;
    logic                   w_stb;
    logic                   w_abort_fire;

    // Candidate index wrap; the search only ever runs one lap past r_last.
    function automatic logic [c_idx_w-1:0] f_wrap(input int v);
        if (v >= NUM_MASTERS) return c_idx_w'(v - NUM_MASTERS);
        return c_idx_w'(v);
    endfunction

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_cand = f_wrap(int'(r_last) + i);
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // Slave-side mux: AND-OR with the one-hot grant so everything reads 0 when idle.
    always_comb begin
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        w_we  = 1'b0;
        w_cyc = 1'b0;
        w_stb = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_adr = w_adr | m_adr_i[32*k +: 32];
                w_dat = w_dat | m_dat_i[32*k +: 32];
                w_sel = w_sel | m_sel_i[4*k +: 4];
                w_we  = w_we  | m_we_i[k];
                w_cyc = w_cyc | m_cyc_i[k];
                w_stb = w_stb | m_stb_i[k];
            end
        end
    end

    assign s_adr_o   = w_adr;
    assign s_dat_o   = w_dat;
    assign s_sel_o   = w_sel;
    assign s_we_o    = w_we;
    assign s_cyc_o   = w_cyc;
    assign s_stb_o   = w_stb & ~r_abort;   // strobe suppressed in the abort cycle
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = r_grant & {NUM_MASTERS{s_ack_i}};
    assign m_err_o   = r_err;
    assign grant_o   = r_grant;
    assign timeout_o = r_timeout;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_state_nxt = c_st_grant;
                    w_grant_nxt = c_one << w_pick;
                    w_gidx_nxt  = w_pick;
                end
            end
            c_st_grant: begin
                // Owner dropping cyc (with or without ack) ends ownership.
                if (!m_cyc_i[r_gidx]) begin
                    w_state_nxt = c_st_idle;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= c_idx_w'(NUM_MASTERS - 1);
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            if (w_abort_fire) begin
                r_timeout <= 1'b1;
            end else if (timeout_clr_i) begin
                r_timeout <= 1'b0;
            end
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT_CYCLES - 1);
            localparam logic [c_wdog_w-1:0] c_wdog_max  = '1;
            logic w_stall;

            assign w_stall      = s_cyc_o & s_stb_o & ~s_ack_i;
            // An ack in the final stall cycle clears w_stall, so the ack wins.
            assign w_abort_fire = w_stall && (r_wdog == c_wdog_last);

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wdog  <= '0;
                    r_abort <= 1'b0;
                    r_err   <= '0;
                end else begin
                    r_abort <= 1'b0;
                    r_err   <= '0;
                    if (w_abort_fire) begin
                        r_abort <= 1'b1;
                        r_err   <= r_grant;
                        r_wdog  <= '0;
                    end else if (w_stall) begin
                        if (r_wdog != c_wdog_max) begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end else begin
                        r_wdog <= '0;
                    end
                end
            end
        end else begin : g_no_wdog
            assign w_abort_fire = 1'b0;

            always_ff @(posedge clk) begin
                r_wdog  <= '0;
                r_abort <= 1'b0;
                r_err   <= '0;
            end
        end
    endgenerate

endmodule

`default_nettype wire
